// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq
//   Sequential BCD-to-binary converter using reverse double-dabble.
//   A start in IDLE captures bcd_in, then BIN_W SHIFT cycles move the BCD
//   register right into the binary accumulator, subtracting 3 from any BCD
//   nibble that reaches 8 or more. The result appears on binary with a
//   one-cycle done pulse.
//
// Parameters
//   DIGITS        number of packed BCD digits on bcd_in (default 3)
//   BIN_W         result width, 2**BIN_W must exceed 10**DIGITS-1 (default 10)
//
// Ports
//   CLOCK_50      in   system clock, rising edge
//   reset_button  in   asynchronous active-low reset
//   start         in   conversion request, sampled only in IDLE
//   bcd_in        in   packed BCD, most significant digit in the top nibble
//   busy          out  high while SHIFT is active
//   done          out  one-cycle pulse when binary holds a fresh result
//   binary        out  converted value, held until the next accepted start
//   error         out  invalid-digit flag (only with BCD_DIGIT_CHECK_EN)
//
// Configuration macro
//   BCD_DIGIT_CHECK_EN  adds the error port: a captured nibble above 9 skips
//                       the shift sequence and finishes with binary=0, error=1.
module bcd_to_binary_seq #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_button,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
`ifdef BCD_DIGIT_CHECK_EN
  output logic [BIN_W-1:0]      binary,
  output logic                  error
`else
  output logic [BIN_W-1:0]      binary
`endif
);

  localparam int unsigned CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [4*DIGITS-1:0]         r_bcd;
  logic [BIN_W-1:0]            r_acc;
  logic [CW-1:0]               r_cnt;
  logic [BIN_W-1:0]            r_binary;
  logic                        w_accept;
  logic                        w_last;
  logic [4*DIGITS+BIN_W-1:0]   w_cat;
  logic [4*DIGITS-1:0]         w_bcd_adj;
  logic [BIN_W-1:0]            w_acc_sh;

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_cnt == CW'(BIN_W - 1));
  assign busy     = (r_state == SHIFT);
  assign done     = (r_state == DONE);
  assign binary   = r_binary;

  // One reverse double-dabble step: shift the pair right, then pull every
  // BCD nibble that now reads 8..15 back down by 3.
  always_comb begin
    w_cat     = {r_bcd, r_acc} >> 1;
    w_acc_sh  = w_cat[BIN_W-1:0];
    w_bcd_adj = w_cat[4*DIGITS+BIN_W-1:BIN_W];
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (w_bcd_adj[4*d +: 4] >= 4'd8) begin
        w_bcd_adj[4*d +: 4] = w_bcd_adj[4*d +: 4] - 4'd3;
      end
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic r_error;
  logic w_bad;

  assign error = r_error;

  always_comb begin
    w_bad = 1'b0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (bcd_in[4*d +: 4] > 4'd9) begin
        w_bad = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge CLOCK_50 or negedge reset_button) begin
    if (!reset_button) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
`ifdef BCD_DIGIT_CHECK_EN
        // An invalid capture spends a single cycle here before DONE.
        if (w_last || r_error) begin
          w_state_nxt = DONE;
        end
`else
        if (w_last) begin
          w_state_nxt = DONE;
        end
`endif
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_button) begin
    if (!reset_button) begin
      r_bcd    <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_binary <= '0;
`ifdef BCD_DIGIT_CHECK_EN
      r_error  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_bcd    <= bcd_in;
      r_acc    <= '0;
      r_cnt    <= '0;
`ifdef BCD_DIGIT_CHECK_EN
      r_error  <= w_bad;
`endif
    end else if (r_state == SHIFT) begin
      r_bcd <= w_bcd_adj;
      r_acc <= w_acc_sh;
      r_cnt <= r_cnt + CW'(1);
`ifdef BCD_DIGIT_CHECK_EN
      if (r_error) begin
        r_binary <= '0;
      end else if (w_last) begin
        r_binary <= w_acc_sh;
      end
`else
      // The final shifted accumulator is published on the edge entering DONE.
      if (w_last) begin
        r_binary <= w_acc_sh;
      end
`endif
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
module tb_bcd_to_binary_seq;

  localparam int unsigned DIGITS = 3;
  localparam int unsigned BIN_W  = 10;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [11:0]       bcd_in;
  logic              busy;
  logic              done;
  logic [BIN_W-1:0]  binary;
`ifdef BCD_DIGIT_CHECK_EN
  logic              error;
`endif

  int unsigned n_checks;
  int unsigned n_fail;
  int unsigned last_result;

  bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .CLOCK_50     (clk),
    .reset_button (rst_n),
    .start        (start),
    .bcd_in       (bcd_in),
    .busy         (busy),
    .done         (done),
`ifdef BCD_DIGIT_CHECK_EN
    .binary       (binary),
    .error        (error)
`else
    .binary       (binary)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: the decimal value of the packed digits.
  function automatic int unsigned bcd_value(input logic [11:0] b);
    int unsigned v;
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      v = v * 10 + int'(b[4*i +: 4]);
    end
    return v;
  endfunction

  // Full conversion with cycle-accurate checks. spur>0 raises start with a
  // different operand during that SHIFT cycle; no_wait drives start at once.
  task automatic convert(input logic [11:0] bcd, input int spur, input bit no_wait);
    int unsigned exp;
    int unsigned bad_busy;
    int unsigned bad_hold;
    exp = bcd_value(bcd);
    if (!no_wait) @(negedge clk);
    start  = 1'b1;
    bcd_in = bcd;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bcd_in = 12'($urandom);
    check_eq("busy_after_accept", busy, 1);
    check_eq("done_after_accept", done, 0);
    bad_busy = 0;
    bad_hold = 0;
    for (int i = 1; i < int'(BIN_W); i++) begin
      if (i == spur) begin
        start  = 1'b1;
        bcd_in = 12'h042;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
      if (binary !== BIN_W'(last_result)) bad_hold++;
    end
    check_eq("busy_window", bad_busy, 0);
    check_eq("binary_held_while_busy", bad_hold, 0);
    @(posedge clk);
    #1;
    check_eq("done_pulse", done, 1);
    check_eq("busy_at_done", busy, 0);
    check_eq("binary_result", binary, exp);
    @(posedge clk);
    #1;
    check_eq("done_one_cycle", done, 0);
    check_eq("binary_hold_after", binary, exp);
    last_result = exp;
  endtask

  initial begin
    int unsigned bad;
    logic [11:0] r;
    n_checks    = 0;
    n_fail      = 0;
    last_result = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = 12'h000;
    #3;
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_binary", binary, 0);
`ifdef BCD_DIGIT_CHECK_EN
    check_eq("reset_error", error, 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    convert(12'h255, 0, 1'b0);
    convert(12'h999, 0, 1'b0);
    convert(12'h000, 0, 1'b0);

    // Start during SHIFT is dropped, no extra done follows.
    convert(12'h128, 4, 1'b0);
    bad = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    check_eq("ignored_start_no_activity", bad, 0);
    check_eq("ignored_start_binary", binary, 128);
    convert(12'h042, 0, 1'b0);

    // Reset in SHIFT cycle 5 aborts the conversion.
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h777;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_binary", binary, 0);
    last_result = 0;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) bad++;
    end
    check_eq("no_done_after_abort", bad, 0);

    // Start presented together with reset release is taken on the first edge.
    @(negedge clk);
    rst_n = 1'b0;
    last_result = 0;
    @(negedge clk);
    rst_n = 1'b1;
    convert(12'h360, 0, 1'b1);

    for (int n = 0; n < 20; n++) begin
      r = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      convert(r, 0, 1'b0);
    end

`ifdef BCD_DIGIT_CHECK_EN
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h1A3;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("err_no_done_at_k", done, 0);
    @(posedge clk);
    #1;
    check_eq("err_done_k1", done, 1);
    check_eq("err_flag", error, 1);
    check_eq("err_binary", binary, 0);
    @(posedge clk);
    #1;
    check_eq("err_done_one_cycle", done, 0);
    check_eq("err_flag_held", error, 1);
    last_result = 0;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h013;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("err_cleared_at_accept", error, 0);
    repeat (BIN_W) @(posedge clk);
    #1;
    check_eq("after_err_done", done, 1);
    check_eq("after_err_binary", binary, 13);
    @(posedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
